pci_tgt_reg_slave: RTL and testbench
====================================

Name: pci_tgt_reg_slave

Overview:
AXI4-Lite responder for the register-space port driven by the PCI target bridge. It answers single-beat writes and reads, holds the device's control and status registers, and latches hardware interrupt sources. It produces the level interrupt request that the PCI core drives onto INTA_N. It sits in the CLK/RST domain of the PCI core, on the far side of the tgt_m_* AXI master.

Parameters:
ADDR_BITS, 24, decoded address width; s_awaddr/s_araddr bits above ADDR_BITS-1 are ignored.
NUM_REGS, 16, number of 32-bit registers (4..64). Word index = addr[ADDR_BITS-1:2].
ID_VALUE, 32'h6120_0001, constant returned by register 0.
IRQ_BITS, 8, number of hardware interrupt sources (1..32).

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
s_awaddr  in  32  write address
s_awvalid  in  1  write address valid
s_awready  out  1  write address ready
s_wdata  in  32  write data
s_wstrb  in  4  write byte strobes
s_wvalid  in  1  write data valid
s_wready  out  1  write data ready
s_bresp  out  2  write response
s_bvalid  out  1  write response valid
s_bready  in  1  write response ready
s_araddr  in  32  read address
s_aruser  in  4  PCI byte enables, active-high (1 = lane wanted)
s_arvalid  in  1  read address valid
s_arready  out  1  read address ready
s_rdata  out  32  read data
s_rresp  out  2  read response
s_rvalid  out  1  read data valid
s_rready  in  1  read data ready
irq_src  in  IRQ_BITS  hardware event inputs, synchronous to CLK
reg_out  out  32*NUM_REGS  flat image of all registers; reg i at bits [32i+31:32i]
intr_request  out  1  interrupt request, active-high

Behaviour:
- Single clock CLK. Reset is synchronous and active-high on RST.
- Register map:
  - 0x00 ID: read-only, ID_VALUE; writes are ignored and return OKAY.
  - 0x04 SCRATCH: RW.
  - 0x08 INT_STATUS: W1C, bits [IRQ_BITS-1:0] only; upper bits read 0.
  - 0x0C INT_MASK: RW, bits [IRQ_BITS-1:0] only.
  - 0x10 up to (NUM_REGS-1)*4: general RW.
- Index >= NUM_REGS: write has no effect, bresp=2'b10 (SLVERR); read returns rdata=0, rresp=2'b10.
- Reset values: all registers 0 except ID. Also at reset: s_awready=1, s_wready=1, s_arready=1, s_bvalid=0, s_rvalid=0, s_bresp=0, s_rresp=0, s_rdata=0, intr_request=0, edge-detect history=0.
- Write channel:
  - AW and W are accepted independently and in either order.
  - awready drops on the cycle after an AW handshake and stays low until the B handshake; wready behaves the same for W.
  - Commit happens on the first cycle both are latched. Register update and bvalid=1 both appear one cycle after the later of the two handshakes.
  - bvalid is held until bready; awready and wready return to 1 the cycle after the B handshake.
  - Byte lane k is written only if s_wstrb[k]=1.
  - INT_STATUS write: bits set in the strobed data are cleared.
- Read channel:
  - AR handshake when arvalid & arready; arready then drops.
  - rvalid=1 the next cycle, rdata registered, held stable until rready.
  - arready returns to 1 the cycle after the R handshake.
  - rdata lane k is forced to 0 when s_aruser[k]=0.
- Read/write ordering: read and write channels are independent. A read issued in the same cycle as a write commit returns the pre-write value.
- Interrupt sources:
  - Each irq_src bit is edge-detected against a one-cycle registered copy; a 0->1 transition sets the matching INT_STATUS bit on the next cycle.
  - A hardware set and a W1C of the same bit in the same cycle: set wins and the bit stays 1.
- intr_request is registered: intr_request <= |(INT_STATUS & INT_MASK), so it follows register state with one cycle of latency.
- reg_out reflects register contents with no additional latency; the ID slot carries ID_VALUE.
- RST asserted mid-transaction:
  - Pending AW/W/AR and any B/R response are discarded; outputs return to reset values on the next edge.
  - No response is issued for the aborted transaction.

Test Plan:
- Read 0x00 with aruser=4'hF -> rvalid one cycle after the AR handshake, rdata=32'h6120_0001, rresp=0. Repeat with aruser=4'h3 -> rdata=32'h0000_0001.
- Write W before AW to 0x04 with wdata=32'hA5A5_1234, wstrb=4'b0101 (prior value 0) -> bresp=0, then reading 0x04 returns 32'h00A5_0034. Hold bready=0 for 5 cycles -> bvalid stays 1, awready and wready stay 0.
- Pulse irq_src[2]; write INT_MASK=32'h4 -> INT_STATUS=32'h4, intr_request=1. Write INT_STATUS=32'h4 -> intr_request=0 two cycles after commit.
- Pulse irq_src[1] rising in the same cycle a W1C of 32'h2 commits -> INT_STATUS bit 1 remains 1.
- Write 0x40 with NUM_REGS=16 -> bresp=2'b10, all registers unchanged. Read 0x40 -> rdata=0, rresp=2'b10.
- Assert RST while rvalid=1 and rready=0 -> next cycle rvalid=0 and arready=1. A subsequent read of 0x04 returns 0.

Source files
------------

// File: rtl/pci_tgt_reg_slave.sv
// AXI4-Lite register responder behind the PCI target bridge.
// Holds the ID, scratch, interrupt status/mask and general registers.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*     AXI4-Lite write address, data and response
//   s_ar*/s_r*          AXI4-Lite read address and data (s_aruser = lanes)
//   irq_src             hardware event inputs (rising edge sets INT_STATUS)
//   reg_out             flat image of all registers, reg i at [32i+31:32i]
//   intr_request        registered |(INT_STATUS & INT_MASK)
module pci_tgt_reg_slave #(
    parameter int          ADDR_BITS = 24,
    parameter int          NUM_REGS  = 16,
    parameter logic [31:0] ID_VALUE  = 32'h6120_0001,
    parameter int          IRQ_BITS  = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [31:0]              s_awaddr,
    input  logic                     s_awvalid,
    output logic                     s_awready,
    input  logic [31:0]              s_wdata,
    input  logic [3:0]               s_wstrb,
    input  logic                     s_wvalid,
    output logic                     s_wready,
    output logic [1:0]               s_bresp,
    output logic                     s_bvalid,
    input  logic                     s_bready,
    input  logic [31:0]              s_araddr,
    input  logic [3:0]               s_aruser,
    input  logic                     s_arvalid,
    output logic                     s_arready,
    output logic [31:0]              s_rdata,
    output logic [1:0]               s_rresp,
    output logic                     s_rvalid,
    input  logic                     s_rready,
    input  logic [IRQ_BITS-1:0]      irq_src,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic                     intr_request
);

    localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int AW = ADDR_BITS - 2;
    localparam logic [31:0] IRQ_MASK = 32'((64'd1 << IRQ_BITS) - 64'd1);

    function automatic logic [31:0] lanes(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    logic          awready_q, wready_q, arready_q;
    logic          bvalid_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [31:0]   rdata_q;
    logic          aw_have_q, w_have_q;
    logic [AW-1:0] awidx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   regs_q [NUM_REGS];
    logic [31:0]   regs_d [NUM_REGS];
    logic [IRQ_BITS-1:0] irq_prev_q;
    logic          intr_q;

    logic          aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic          commit, w_ok, r_ok;
    logic [AW-1:0] w_idx, r_idx;
    logic [31:0]   w_data, w_be, merged, rise;
    logic [31:0]   rd_word, rd_data;
    logic [3:0]    w_strb;

    // Upper and byte-offset address bits are not decoded.
    logic unused_addr;
    assign unused_addr = ^{s_awaddr[31:ADDR_BITS], s_awaddr[1:0],
                           s_araddr[31:ADDR_BITS], s_araddr[1:0]};

    assign aw_hs = s_awvalid & awready_q;
    assign w_hs  = s_wvalid & wready_q;
    assign ar_hs = s_arvalid & arready_q;
    assign b_hs  = bvalid_q & s_bready;
    assign r_hs  = rvalid_q & s_rready;

    // Commit on the handshake edge itself when the other half is already
    // held, so the register and bvalid are visible the following cycle.
    assign w_idx  = aw_have_q ? awidx_q : s_awaddr[ADDR_BITS-1:2];
    assign w_data = w_have_q ? wdata_q : s_wdata;
    assign w_strb = w_have_q ? wstrb_q : s_wstrb;
    assign commit = (aw_have_q | aw_hs) & (w_have_q | w_hs);
    assign w_ok   = w_idx < AW'(NUM_REGS);
    assign w_be   = lanes(w_strb);
    assign merged = (regs_q[w_idx[IW-1:0]] & ~w_be) | (w_data & w_be);
    assign rise   = 32'(irq_src & ~irq_prev_q);

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) regs_d[i] = regs_q[i];
        if (commit && w_ok) begin
            if (w_idx == AW'(0)) begin
                regs_d[0] = '0;
            end else if (w_idx == AW'(2)) begin
                regs_d[2] = regs_q[2] & ~(w_data & w_be);
            end else if (w_idx == AW'(3)) begin
                regs_d[3] = merged & IRQ_MASK;
            end else begin
                regs_d[w_idx[IW-1:0]] = merged;
            end
        end
        regs_d[0] = '0;
        // Hardware set is applied after the W1C so it wins a collision.
        regs_d[2] = (regs_d[2] | rise) & IRQ_MASK;
    end

    assign r_idx   = s_araddr[ADDR_BITS-1:2];
    assign r_ok    = r_idx < AW'(NUM_REGS);
    assign rd_word = (r_idx == AW'(0)) ? ID_VALUE : regs_q[r_idx[IW-1:0]];
    assign rd_data = r_ok ? (rd_word & lanes(s_aruser)) : 32'h0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            arready_q  <= 1'b1;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            irq_prev_q <= '0;
            intr_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
            irq_prev_q <= irq_src;
            intr_q     <= |(regs_q[2] & regs_q[3]);
            aw_have_q  <= (aw_have_q | aw_hs) & ~commit;
            w_have_q   <= (w_have_q | w_hs) & ~commit;
            if (aw_hs) begin
                awready_q <= 1'b0;
                awidx_q   <= s_awaddr[ADDR_BITS-1:2];
            end
            if (w_hs) begin
                wready_q <= 1'b0;
                wdata_q  <= s_wdata;
                wstrb_q  <= s_wstrb;
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= w_ok ? 2'b00 : 2'b10;
            end
            if (b_hs) begin
                bvalid_q  <= 1'b0;
                awready_q <= 1'b1;
                wready_q  <= 1'b1;
            end
            if (ar_hs) begin
                arready_q <= 1'b0;
                rvalid_q  <= 1'b1;
                rdata_q   <= rd_data;
                rresp_q   <= r_ok ? 2'b00 : 2'b10;
            end
            if (r_hs) begin
                rvalid_q  <= 1'b0;
                arready_q <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[32*g +: 32] = (g == 0) ? ID_VALUE : regs_q[g];
    end

    assign s_awready    = awready_q;
    assign s_wready     = wready_q;
    assign s_arready    = arready_q;
    assign s_bvalid     = bvalid_q;
    assign s_bresp      = bresp_q;
    assign s_rvalid     = rvalid_q;
    assign s_rresp      = rresp_q;
    assign s_rdata      = rdata_q;
    assign intr_request = intr_q;

endmodule

// File: tb/tb_pci_tgt_reg_slave.sv
// Directed bench for pci_tgt_reg_slave.
// Vector tables for writes/reads plus hand sequences for IRQ and reset.
module tb_pci_tgt_reg_slave;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [31:0]  awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [31:0]  araddr = '0;
    logic [3:0]   aruser = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic [7:0]   irq = '0;
    logic [511:0] reg_out;
    logic         intr;

    int total = 0;
    int bad   = 0;

    pci_tgt_reg_slave dut (
        .CLK(clk), .RST(rst),
        .s_awaddr(awaddr), .s_awvalid(awvalid), .s_awready(awready),
        .s_wdata(wdata), .s_wstrb(wstrb), .s_wvalid(wvalid),
        .s_wready(wready),
        .s_bresp(bresp), .s_bvalid(bvalid), .s_bready(bready),
        .s_araddr(araddr), .s_aruser(aruser), .s_arvalid(arvalid),
        .s_arready(arready),
        .s_rdata(rdata), .s_rresp(rresp), .s_rvalid(rvalid),
        .s_rready(rready),
        .irq_src(irq), .reg_out(reg_out), .intr_request(intr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rego(input int i);
        return reg_out[32*i +: 32];
    endfunction

    // mode 0: AW+W together, 1: W then AW, 2: AW then W
    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int mode,
                            input int bhold, output logic [1:0] resp);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s;
        if (mode == 0) begin
            awvalid = 1'b1; wvalid = 1'b1;
        end else if (mode == 1) begin
            wvalid = 1'b1;
        end else begin
            awvalid = 1'b1;
        end
        @(negedge clk);
        if (mode == 1) begin
            chk("wready_drop", {31'b0, wready}, 32'd0);
            wvalid = 1'b0; awvalid = 1'b1;
            @(negedge clk);
        end else if (mode == 2) begin
            chk("awready_drop", {31'b0, awready}, 32'd0);
            awvalid = 1'b0; wvalid = 1'b1;
            @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        chk("bvalid_lat", {31'b0, bvalid}, 32'd1);
        for (int k = 0; k < bhold; k++) begin
            chk("bvalid_hold", {31'b0, bvalid}, 32'd1);
            chk("aw_w_ready_hold", {30'b0, awready, wready}, 32'd0);
            @(negedge clk);
        end
        resp = bresp;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("ready_back", {30'b0, awready, wready}, 32'd3);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] u,
                           output logic [31:0] d, output logic [1:0] resp);
        @(negedge clk);
        araddr = a; aruser = u; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("rvalid_lat", {31'b0, rvalid}, 32'd1);
        d = rdata; resp = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("arready_back", {31'b0, arready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          mode;
        int          bhold;
        logic [1:0]  resp;
    } wr_vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  user;
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_vec_t;

    wr_vec_t     wv [6];
    rd_vec_t     rv [9];
    logic [31:0] exp_r [16];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        wv[0] = '{32'h0000_0004, 32'hA5A5_1234, 4'b0101, 1, 5, 2'b00};
        wv[1] = '{32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0, 2'b00};
        wv[2] = '{32'h0000_0040, 32'hFFFF_FFFF, 4'b1111, 2, 2, 2'b10};
        wv[3] = '{32'h0000_0000, 32'h1234_5678, 4'b1111, 0, 0, 2'b00};
        wv[4] = '{32'h0000_003C, 32'h1122_3344, 4'b1100, 2, 1, 2'b00};
        wv[5] = '{32'h0100_0014, 32'hCAFE_F00D, 4'b0011, 1, 0, 2'b00};

        rv[0] = '{32'h0000_0000, 4'hF, 32'h6120_0001, 2'b00};
        rv[1] = '{32'h0000_0000, 4'h3, 32'h0000_0001, 2'b00};
        rv[2] = '{32'h0000_0004, 4'hF, 32'h00A5_0034, 2'b00};
        rv[3] = '{32'h0000_0010, 4'hA, 32'hDE00_BE00, 2'b00};
        rv[4] = '{32'h0000_0040, 4'hF, 32'h0000_0000, 2'b10};
        rv[5] = '{32'h0000_003C, 4'hF, 32'h1122_0000, 2'b00};
        rv[6] = '{32'h0100_0004, 4'hF, 32'h00A5_0034, 2'b00};
        rv[7] = '{32'h0000_0014, 4'h1, 32'h0000_000D, 2'b00};
        rv[8] = '{32'h0000_00FC, 4'hF, 32'h0000_0000, 2'b10};

        for (int i = 0; i < 16; i++) exp_r[i] = '0;
        exp_r[0]  = 32'h6120_0001;
        exp_r[1]  = 32'h00A5_0034;
        exp_r[4]  = 32'hDEAD_BEEF;
        exp_r[5]  = 32'h0000_F00D;
        exp_r[15] = 32'h1122_0000;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {29'b0, awready, wready, arready}, 32'd7);
        chk("rst_valid", {30'b0, bvalid, rvalid}, 32'd0);
        chk("rst_resp", {28'b0, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_intr", {31'b0, intr}, 32'd0);
        chk("rst_id", rego(0), 32'h6120_0001);
        chk("rst_scratch", rego(1), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_write(wv[i].addr, wv[i].data, wv[i].strb,
                     wv[i].mode, wv[i].bhold, r);
            chk($sformatf("wr%0d_bresp", i), {30'b0, r}, {30'b0, wv[i].resp});
        end
        for (int i = 0; i < 16; i++)
            chk($sformatf("reg_out%0d", i), rego(i), exp_r[i]);

        for (int i = 0; i < 9; i++) begin
            do_read(rv[i].addr, rv[i].user, d, r);
            chk($sformatf("rd%0d_data", i), d, rv[i].data);
            chk($sformatf("rd%0d_resp", i), {30'b0, r}, {30'b0, rv[i].resp});
        end

        // read in the same cycle as a write commit sees the old value
        @(negedge clk);
        awaddr = 32'h18; wdata = 32'h55; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h18; aruser = 4'hF; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("raw_rvalid", {31'b0, rvalid}, 32'd1);
        chk("raw_old", rdata, 32'd0);
        chk("raw_bvalid", {31'b0, bvalid}, 32'd1);
        rready = 1'b1; bready = 1'b1;
        @(negedge clk);
        rready = 1'b0; bready = 1'b0;
        do_read(32'h18, 4'hF, d, r);
        chk("raw_new", d, 32'h55);

        // interrupt raise, mask, W1C
        @(negedge clk);
        irq = 8'h04;
        @(negedge clk);
        irq = 8'h00;
        chk("irq2_set", rego(2), 32'h4);
        chk("irq_unmasked", {31'b0, intr}, 32'd0);
        do_write(32'h0C, 32'hFFFF_FF04, 4'hF, 0, 0, r);
        chk("mask_val", rego(3), 32'h4);
        chk("intr_on", {31'b0, intr}, 32'd1);
        do_read(32'h08, 4'hF, d, r);
        chk("status_rd", d, 32'h4);

        @(negedge clk);
        awaddr = 32'h08; wdata = 32'h4; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("w1c_clear", rego(2), 32'h0);
        chk("intr_lag", {31'b0, intr}, 32'd1);
        @(negedge clk);
        chk("intr_off", {31'b0, intr}, 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;

        // hardware set wins over a colliding W1C
        @(negedge clk);
        irq = 8'h02;
        @(negedge clk);
        irq = 8'h00;
        chk("irq1_set", rego(2), 32'h2);
        @(negedge clk);
        awaddr = 32'h08; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; irq = 8'h02;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; irq = 8'h00;
        chk("set_wins", rego(2), 32'h2);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk("intr_masked", {31'b0, intr}, 32'd0);
        do_write(32'h08, 32'h2, 4'h1, 0, 0, r);
        chk("w1c_bit1", rego(2), 32'h0);

        // reset with a read response pending
        @(negedge clk);
        araddr = 32'h04; aruser = 4'hF; arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        chk("pre_rst_rvalid", {31'b0, rvalid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
        chk("rst_mid_arready", {31'b0, arready}, 32'd1);
        chk("rst_mid_scratch", rego(1), 32'd0);
        do_read(32'h04, 4'hF, d, r);
        chk("post_rst_read", d, 32'd0);
        chk("post_rst_resp", {30'b0, r}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
